// File: rtl/rst_seq_pkg.sv
// Shared types and sizing helpers for the power-up/reset sequencer.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    S_HOLD       = 3'd0,
    S_WAIT_LOCK  = 3'd1,
    S_WAIT_START = 3'd2,
    S_STAGE      = 3'd3,
    S_RUN        = 3'd4
  } rst_state_e;

  localparam int RELOCK_W = 8;

  // One width shared by every internal counter: enough for the largest terminal count.
  function automatic int cnt_w(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/rst_seq_sync.sv
// Two-flop synchronizer for asynchronous level inputs; synchronous active-low reset to 0.
module rst_seq_sync #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: waits for stable PLL lock and a debounced start press, then releases
// subsystem resets one stage at a time. RST_SEQ_PHY_EN adds pll2_lock to the lock qualifier.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int N_STAGE     = 4,
  parameter int LOCK_STABLE = 256,
  parameter int DEBOUNCE    = 1024,
  parameter int STAGE_DLY   = 16
) (
  input  logic                clk_50_0,
  input  logic                reset_in,
  input  logic                pll1_lock,
  input  logic                pll2_lock,
  input  logic                start,
  output logic [N_STAGE-1:0]  sub_rst_n,
  output logic                done,
  output logic                fault,
  output logic [RELOCK_W-1:0] relock_cnt,
  output logic [2:0]          state
);

  localparam int CW = cnt_w(LOCK_STABLE, DEBOUNCE, STAGE_DLY, N_STAGE);
  localparam int IW = (N_STAGE > 1) ? $clog2(N_STAGE) : 1;

  localparam logic [CW-1:0] LOCK_TC  = CW'(LOCK_STABLE - 1);
  localparam logic [CW-1:0] DEB_TC   = CW'(DEBOUNCE - 1);
  localparam logic [CW-1:0] DLY_TC   = CW'(STAGE_DLY - 1);
  localparam logic [IW-1:0] STG_LAST = IW'(N_STAGE - 1);

  logic pll1_s;
  logic start_s;
  logic lock_ok;

  rst_seq_sync #(.W(1)) u_sync_pll1 (
    .clk_i  (clk_50_0),
    .rst_ni (reset_in),
    .d_i    (pll1_lock),
    .q_o    (pll1_s)
  );

  rst_seq_sync #(.W(1)) u_sync_start (
    .clk_i  (clk_50_0),
    .rst_ni (reset_in),
    .d_i    (start),
    .q_o    (start_s)
  );

`ifdef RST_SEQ_PHY_EN
  logic pll2_s;

  rst_seq_sync #(.W(1)) u_sync_pll2 (
    .clk_i  (clk_50_0),
    .rst_ni (reset_in),
    .d_i    (pll2_lock),
    .q_o    (pll2_s)
  );

  assign lock_ok = pll1_s & pll2_s;
`else
  logic unused_pll2;
  assign unused_pll2 = pll2_lock;
  assign lock_ok     = pll1_s;
`endif

  rst_state_e            state_q, state_d;
  logic [CW-1:0]         lock_cnt_q, lock_cnt_d;
  logic [CW-1:0]         deb_cnt_q, deb_cnt_d;
  logic [CW-1:0]         dly_cnt_q, dly_cnt_d;
  logic [IW-1:0]         stg_idx_q, stg_idx_d;
  logic                  start_seen_q, start_seen_d;
  logic [N_STAGE-1:0]    sub_rst_q, sub_rst_d;
  logic                  done_q, done_d;
  logic                  fault_q, fault_d;
  logic [RELOCK_W-1:0]   relock_q, relock_d;

  always_ff @(posedge clk_50_0) begin
    if (!reset_in) begin
      state_q      <= S_HOLD;
      lock_cnt_q   <= '0;
      deb_cnt_q    <= '0;
      dly_cnt_q    <= '0;
      stg_idx_q    <= '0;
      start_seen_q <= 1'b0;
      sub_rst_q    <= '0;
      done_q       <= 1'b0;
      fault_q      <= 1'b0;
      relock_q     <= '0;
    end else begin
      state_q      <= state_d;
      lock_cnt_q   <= lock_cnt_d;
      deb_cnt_q    <= deb_cnt_d;
      dly_cnt_q    <= dly_cnt_d;
      stg_idx_q    <= stg_idx_d;
      start_seen_q <= start_seen_d;
      sub_rst_q    <= sub_rst_d;
      done_q       <= done_d;
      fault_q      <= fault_d;
      relock_q     <= relock_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    lock_cnt_d   = lock_cnt_q;
    deb_cnt_d    = deb_cnt_q;
    dly_cnt_d    = dly_cnt_q;
    stg_idx_d    = stg_idx_q;
    start_seen_d = start_seen_q;
    sub_rst_d    = sub_rst_q;
    done_d       = done_q;
    fault_d      = 1'b0;
    relock_d     = relock_q;

    unique case (state_q)
      S_HOLD: begin
        state_d    = S_WAIT_LOCK;
        lock_cnt_d = '0;
        deb_cnt_d  = '0;
        dly_cnt_d  = '0;
        stg_idx_d  = '0;
      end

      S_WAIT_LOCK: begin
        deb_cnt_d = '0;
        if (!lock_ok) begin
          lock_cnt_d = '0;
        end else if (lock_cnt_q == LOCK_TC) begin
          lock_cnt_d = '0;
          dly_cnt_d  = '0;
          stg_idx_d  = '0;
          state_d    = start_seen_q ? S_STAGE : S_WAIT_START;
        end else begin
          lock_cnt_d = lock_cnt_q + 1'b1;
        end
      end

      S_WAIT_START: begin
        if (!lock_ok) begin
          state_d    = S_WAIT_LOCK;
          lock_cnt_d = '0;
          deb_cnt_d  = '0;
        end else if (start_s) begin
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_TC) begin
          start_seen_d = 1'b1;
          deb_cnt_d    = '0;
          dly_cnt_d    = '0;
          stg_idx_d    = '0;
          state_d      = S_STAGE;
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
      end

      S_STAGE, S_RUN: begin
        // Lock loss outranks a coincident stage release.
        if (!lock_ok) begin
          sub_rst_d  = '0;
          done_d     = 1'b0;
          fault_d    = 1'b1;
          if (relock_q != '1) relock_d = relock_q + 1'b1;
          state_d    = S_WAIT_LOCK;
          lock_cnt_d = '0;
          deb_cnt_d  = '0;
          dly_cnt_d  = '0;
          stg_idx_d  = '0;
        end else if (state_q == S_STAGE) begin
          if (dly_cnt_q == DLY_TC) begin
            sub_rst_d[stg_idx_q] = 1'b1;
            dly_cnt_d            = '0;
            if (stg_idx_q == STG_LAST) begin
              done_d  = 1'b1;
              state_d = S_RUN;
            end else begin
              stg_idx_d = stg_idx_q + 1'b1;
            end
          end else begin
            dly_cnt_d = dly_cnt_q + 1'b1;
          end
        end
      end

      default: state_d = S_HOLD;
    endcase
  end

  assign sub_rst_n  = sub_rst_q;
  assign done       = done_q;
  assign fault      = fault_q;
  assign relock_cnt = relock_q;
  assign state      = state_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl with N_STAGE=3, LOCK_STABLE=8, DEBOUNCE=4, STAGE_DLY=3.
module tb_rst_seq_ctrl;

  logic       clk_50_0 = 1'b0;
  logic       reset_in;
  logic       pll1_lock;
  logic       pll2_lock;
  logic       start;
  logic [2:0] sub_rst_n;
  logic       done;
  logic       fault;
  logic [7:0] relock_cnt;
  logic [2:0] state;

  int n_cmp = 0;
  int n_err = 0;

  rst_seq_ctrl #(
    .N_STAGE(3), .LOCK_STABLE(8), .DEBOUNCE(4), .STAGE_DLY(3)
  ) dut (
    .clk_50_0   (clk_50_0),
    .reset_in   (reset_in),
    .pll1_lock  (pll1_lock),
    .pll2_lock  (pll2_lock),
    .start      (start),
    .sub_rst_n  (sub_rst_n),
    .done       (done),
    .fault      (fault),
    .relock_cnt (relock_cnt),
    .state      (state)
  );

  always #10 clk_50_0 = ~clk_50_0;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_50_0);
      #1;
    end
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  int w;
  int nflt;

  initial begin
    reset_in  = 1'b0;
    pll1_lock = 1'b0;
    pll2_lock = 1'b0;
    start     = 1'b1;
    tick(2);
    chk("rst_state", state, 0);
    chk("rst_sub", sub_rst_n, 0);
    chk("rst_done", done, 0);
    chk("rst_fault", fault, 0);
    chk("rst_relock", relock_cnt, 0);

    // Nominal bring-up
    reset_in  = 1'b1;
    pll1_lock = 1'b1;
    pll2_lock = 1'b1;
    tick(9);
    chk("nom_wl", state, 1);
    tick(1);
    chk("nom_ws", state, 2);
    start = 1'b0;
    tick(5);
    chk("nom_ws2", state, 2);
    tick(1);
    chk("nom_stage", state, 3);
    start = 1'b1;
    tick(2);
    chk("nom_sub_t2", sub_rst_n, 0);
    tick(1);
    chk("nom_sub_t3", sub_rst_n, 1);
    tick(2);
    chk("nom_sub_t5", sub_rst_n, 1);
    tick(1);
    chk("nom_sub_t6", sub_rst_n, 3);
    tick(2);
    chk("nom_sub_t8", sub_rst_n, 3);
    chk("nom_done_t8", done, 0);
    tick(1);
    chk("nom_sub_t9", sub_rst_n, 7);
    chk("nom_done_t9", done, 1);
    chk("nom_run", state, 4);

    // Lock drop in RUN, automatic relock without start
    pll1_lock = 1'b0;
    tick(1);
    pll1_lock = 1'b1;
    tick(1);
    chk("drop_sub_e2", sub_rst_n, 7);
    chk("drop_done_e2", done, 1);
    tick(1);
    chk("drop_sub_e3", sub_rst_n, 0);
    chk("drop_done_e3", done, 0);
    chk("drop_fault_e3", fault, 1);
    chk("drop_relock", relock_cnt, 1);
    chk("drop_state", state, 1);
    tick(1);
    chk("drop_fault_e4", fault, 0);
    tick(6);
    chk("relock_wl", state, 1);
    tick(1);
    chk("relock_stage", state, 3);
    tick(9);
    chk("relock_run", state, 4);
    chk("relock_sub", sub_rst_n, 7);

    // Reset mid-STAGE
    pll1_lock = 1'b0;
    tick(1);
    pll1_lock = 1'b1;
    tick(2);
    chk("rs_relock2", relock_cnt, 2);
    tick(8);
    chk("rs_stage", state, 3);
    tick(3);
    chk("rs_sub1", sub_rst_n, 1);
    reset_in = 1'b0;
    tick(1);
    chk("rs_state", state, 0);
    chk("rs_sub", sub_rst_n, 0);
    chk("rs_done", done, 0);
    chk("rs_fault", fault, 0);
    chk("rs_relock", relock_cnt, 0);
    reset_in = 1'b1;
    tick(9);
    chk("rs_wl", state, 1);
    tick(1);
    chk("rs_ws_seen_clr", state, 2);

    // Bounce on start
    start = 1'b0;
    tick(3);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(2);
    chk("bnc_b6", state, 2);
    tick(3);
    chk("bnc_b9", state, 2);
    tick(1);
    chk("bnc_stage", state, 3);
    tick(9);
    chk("bnc_run", state, 4);
    chk("bnc_sub", sub_rst_n, 7);
    start = 1'b1;

    // Lock flicker in WAIT_LOCK
    reset_in  = 1'b0;
    pll1_lock = 1'b0;
    tick(1);
    reset_in  = 1'b1;
    pll1_lock = 1'b1;
    tick(5);
    pll1_lock = 1'b0;
    tick(1);
    pll1_lock = 1'b1;
    tick(9);
    chk("flk_wl", state, 1);
    tick(1);
    chk("flk_ws", state, 2);
    chk("flk_relock", relock_cnt, 0);

    // pll2 held low with start pressed
    reset_in  = 1'b0;
    pll2_lock = 1'b0;
    start     = 1'b0;
    tick(1);
    reset_in = 1'b1;
    tick(22);
`ifdef RST_SEQ_PHY_EN
    chk("phy_sub_g23", sub_rst_n, 0);
    tick(1);
    chk("phy_state", state, 1);
    chk("phy_done", done, 0);
`else
    chk("phy_sub_g23", sub_rst_n, 3);
    tick(1);
    chk("phy_state", state, 4);
    chk("phy_done", done, 1);
`endif

    // Relock counter saturation
    pll2_lock = 1'b1;
    nflt = 0;
    for (int i = 0; i < 260; i++) begin
      w = 0;
      while (!(state == 3'd3 || state == 3'd4) && w < 200) begin
        tick(1);
        w++;
      end
      if (w >= 200) begin
        chk("sat_wait", state, 3);
        break;
      end
      pll1_lock = 1'b0;
      tick(1);
      pll1_lock = 1'b1;
      tick(2);
      if (fault) nflt++;
      tick(1);
    end
    chk("sat_faults", nflt, 260);
    chk("sat_relock", relock_cnt, 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rst_seq_ctrl.md
# rst_seq_ctrl

Power-up and reset sequencer that sits behind the clock manager in the DSP processor. It watches the two PLL lock indicators and the active-low start button. Once clocks are stable and the user has pressed start, it releases per-subsystem active-low resets one stage at a time with a fixed gap between stages. On loss of lock it re-asserts every subsystem reset and re-sequences automatically, and it reports status to the core.

## Interface
- N_STAGE, 4: number of sequenced subsystem resets (2..8)
- LOCK_STABLE, 256: consecutive cycles of lock required before proceeding (≥2)
- DEBOUNCE, 1024: consecutive low cycles of start counted as a press (≥2)
- STAGE_DLY, 16: cycles between successive stage releases (≥1)
- clk_50_0  input  1  50 MHz system clock, the only clock
- reset_in  input  1  synchronous, active-low reset
- pll1_lock  input  1  PLL1 locked, asynchronous
- pll2_lock  input  1  PLL2 (phy clock) locked, asynchronous
- start  input  1  start button, active-low, asynchronous
- sub_rst_n  output  N_STAGE  per-subsystem active-low resets; bit 0 is released first
- done  output  1  all stages released; system running
- fault  output  1  one-cycle pulse on loss of lock during STAGE or RUN
- relock_cnt  output  8  count of fault events, saturating at 255
- state  output  3  current FSM state encoding, for debug

## Operation
- **Input sync:** pll1_lock, pll2_lock and start each pass through a 2-flop synchronizer. lock_ok = pll1_sync & pll2_sync.
- **FSM states:** HOLD=0, WAIT_LOCK=1, WAIT_START=2, STAGE=3, RUN=4.
- **HOLD:** unconditionally goes to WAIT_LOCK on the next cycle.
- **WAIT_LOCK:**
  - lock_cnt increments while lock_ok=1 and clears to 0 whenever lock_ok=0.
  - At lock_cnt==LOCK_STABLE-1 with lock_ok=1, the FSM leaves WAIT_LOCK. It goes to STAGE if start_seen=1, otherwise to WAIT_START.
- **WAIT_START:**
  - deb_cnt counts consecutive cycles with synced start=0 and clears when start=1.
  - At deb_cnt==DEBOUNCE-1: start_seen is set and the FSM goes to STAGE.
  - lock_ok=0 in this state returns to WAIT_LOCK. No fault, no relock_cnt change.
- **start_seen:** sticky; cleared only by reset_in. A relock after a fault therefore never waits for the button again.
- **STAGE:**
  - On entry, stg_idx=0 and dly_cnt=0.
  - dly_cnt counts up to STAGE_DLY-1. At terminal count, sub_rst_n[stg_idx] is set to 1, dly_cnt clears and stg_idx increments.
  - Releasing bit N_STAGE-1 goes to RUN.
- **RUN:** holds. done=1.
- **Loss of lock (lock_ok=0 in STAGE or RUN):** on the same edge,
  - sub_rst_n becomes all zeros, done=0, fault=1 for one cycle;
  - relock_cnt increments, saturating at 255;
  - state goes to WAIT_LOCK and all counters clear.
- **Ignored input:** start activity in STAGE and RUN is ignored.

## Timing
- **Reset values** (reset_in=0 at an edge):
  - state=HOLD, sub_rst_n=0, done=0, fault=0, relock_cnt=0;
  - start_seen=0, all synchronizer flops 0, all counters 0.
  - This applies mid-sequence as well: a reset during any state aborts the sequence immediately.
- **Registered outputs:** all outputs are registered; no combinational input-to-output path.
- **Input latency:** 2 cycles from a pin change to the synced value.
- **Stage release timing:** with STAGE entered at edge T, sub_rst_n[k] rises at T+(k+1)·STAGE_DLY. done rises on the same edge as sub_rst_n[N_STAGE-1].
- **Lock-drop latency:** a lock drop at the pin deasserts all resets 3 edges later (2 sync + 1 register).
- **Collision:** if lock_ok=0 on the cycle a stage terminal count would release, the lock drop wins and no bit is released.
- **Lock glitch:** a drop shorter than 1 cycle may be missed; that is acceptable. Any sampled 0 restarts lock_cnt.

## Configuration
- **Macro RST_SEQ_PHY_EN:**
  - Defined: lock_ok includes pll2_sync, as above.
  - Undefined: lock_ok = pll1_sync only. pll2_lock stays a port but is unused; its synchronizer is not instantiated. Use this for simulation with no phy clock.

## Structure
- **Package rst_seq_pkg:**
  - state enum (3-bit) and its encodings;
  - RELOCK_W=8 constant;
  - helper function for counter width, clog2 of the maximum of the parameters.
- **Sub-module rst_seq_sync:**
  - parameterized 2-flop synchronizer with synchronous active-low reset to 0;
  - instantiated once per asynchronous input.
- **rst_seq_ctrl:** contains the FSM, counters and output registers.

## Test plan
All scenarios use N_STAGE=3, LOCK_STABLE=8, DEBOUNCE=4, STAGE_DLY=3.

- **Nominal bring-up:** both locks high, then start held low for 6 cycles.
  - Expect WAIT_START after lock_cnt terminal.
  - Expect sub_rst_n = 001, 011, 111 at 3, 6 and 9 cycles after STAGE entry; done=1 together with 111.
- **Bounce:** start low for 3 cycles, high for 1, low for 4.
  - No STAGE after the first 3-cycle pulse.
  - STAGE entered only after 4 consecutive low synced cycles.
- **Lock drop in RUN:** pll1_lock forced 0 for 1 cycle.
  - 3 edges later: sub_rst_n=000, done=0, fault pulses once, relock_cnt=1.
  - After 8 stable lock cycles the FSM re-sequences with no start press.
- **Lock flicker in WAIT_LOCK:** lock high for 5 cycles, low for 1, then high.
  - Total ≥ 2+1+5+8 cycles before WAIT_START; relock_cnt stays 0.
- **Macro off:** pll2_lock held 0, pll1 high, start pressed.
  - Full sequence completes to done=1.
  - With RST_SEQ_PHY_EN defined, the FSM stays in WAIT_LOCK.
- **Reset mid-STAGE:** reset_in=0 for 1 cycle after sub_rst_n=001.
  - Next edge: all outputs at reset values, state=HOLD, start_seen=0.
  - Relock_cnt saturation is checked with 260 forced faults → 255.
